// File: rtl/pic_pkg.sv
// Shared constants, state encoding and priority helpers for the PIC sequencer.
package pic_pkg;

  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;
  localparam logic [IDX_W-1:0] SPURIOUS_IDX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2,
    ACK2 = 2'd3
  } pic_state_e;

  // Distance of a level from the rotation base; 0 is the highest priority.
  // The 3-bit subtraction wraps modulo 8 by construction.
  function automatic logic [IDX_W-1:0] rank(input logic [IDX_W-1:0] idx,
                                            input logic [IDX_W-1:0] base);
    return idx - base;
  endfunction

  // Levels ranked at or above idx for the given base (idx itself included).
  function automatic logic [NUM_IRQ-1:0] at_or_above(input logic [IDX_W-1:0] idx,
                                                     input logic [IDX_W-1:0] base);
    logic [NUM_IRQ-1:0] mask;
    mask = '0;
    for (int j = 0; j < NUM_IRQ; j++) begin
      if (rank(IDX_W'(j), base) <= rank(idx, base)) mask[j] = 1'b1;
    end
    return mask;
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_IRQ'(1) << idx;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating find-first: returns the set bit of i_vec closest to i_base,
// scanning upward and wrapping from 7 to 0.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_vec,
  input  logic [IDX_W-1:0]   i_base,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (i_vec[i_base + IDX_W'(k)]) begin
        o_valid = 1'b1;
        o_idx   = i_base + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/pic_ack_controller.sv
// 8259-style interrupt sequencer: masking, rotating priority, fully nested
// in-service tracking, two-pulse INTA cycle, vector generation and EOI/AEOI.
module pic_ack_controller
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_status,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic [4:0]         vector_base,
  input  logic               aeoi,
  input  logic               rotate_en,
  input  logic               inta_pulse,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [IDX_W-1:0]   eoi_level,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDX_W-1:0]   highest_priority_idx
);

  pic_state_e         r_state;
  pic_state_e         w_state_next;
  logic               r_int_out;
  logic [NUM_IRQ-1:0] r_isr;
  logic [IDX_W-1:0]   r_base;
  logic [IDX_W-1:0]   r_win_idx;
  logic               r_win_valid;
  logic [NUM_IRQ-1:0] r_irr_clear;
  logic [7:0]         r_vector_out;
  logic               r_vector_valid;

  logic [NUM_IRQ-1:0] w_elig;
  logic               w_req_valid;
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_isr_valid;
  logic [IDX_W-1:0]   w_isr_idx;
  logic [NUM_IRQ-1:0] w_eoi_mask;
  logic [IDX_W-1:0]   w_eoi_lvl;
  logic [NUM_IRQ-1:0] w_isr_post;
  logic               w_win_valid;
  logic               w_ack1;
  logic               w_ack2;
  logic [NUM_IRQ-1:0] w_set_mask;
  logic [NUM_IRQ-1:0] w_aeoi_mask;
  logic [IDX_W-1:0]   w_base_next;

  assign w_elig = irq_status & ~imr;

  pic_priority_resolver u_req_resolver (
    .i_vec   (w_elig),
    .i_base  (r_base),
    .o_valid (w_req_valid),
    .o_idx   (w_req_idx)
  );

  pic_priority_resolver u_isr_resolver (
    .i_vec   (r_isr),
    .i_base  (r_base),
    .o_valid (w_isr_valid),
    .o_idx   (w_isr_idx)
  );

  // EOI decode: pick the level to clear; clearing a bit that is already 0 does nothing.
  always_comb begin
    w_eoi_mask = '0;
    w_eoi_lvl  = '0;
    if (eoi_valid) begin
      w_eoi_lvl = eoi_specific ? eoi_level : w_isr_idx;
      if (eoi_specific || w_isr_valid) w_eoi_mask = onehot(w_eoi_lvl) & r_isr;
    end
  end

  // The winner is judged against the in-service set after this cycle's EOI,
  // and must strictly outrank every level still in service.
  assign w_isr_post  = r_isr & ~w_eoi_mask;
  assign w_win_valid = w_req_valid && ((w_isr_post & at_or_above(w_req_idx, r_base)) == '0);

  assign w_ack1 = (r_state == REQ)  && inta_pulse;
  assign w_ack2 = (r_state == ACK1) && inta_pulse;

  assign w_set_mask  = (w_ack1 && w_win_valid) ? onehot(w_req_idx) : '0;
  assign w_aeoi_mask = (w_ack2 && aeoi && r_win_valid) ? onehot(r_win_idx) : '0;

  // Rotation base: an AEOI clear takes precedence over a same-cycle EOI clear.
  always_comb begin
    w_base_next = r_base;
    if (rotate_en && (w_aeoi_mask != '0))     w_base_next = r_win_idx + IDX_W'(1);
    else if (rotate_en && (w_eoi_mask != '0)) w_base_next = w_eoi_lvl + IDX_W'(1);
  end

  // Next-state logic for the request / two-pulse acknowledge sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_win_valid) w_state_next = REQ;
      REQ: begin
        if (inta_pulse)        w_state_next = ACK1;
        else if (!w_win_valid) w_state_next = IDLE;
      end
      ACK1: if (inta_pulse) w_state_next = ACK2;
      ACK2: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, in-service, rotation and acknowledge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_int_out      <= 1'b0;
      r_isr          <= '0;
      r_base         <= '0;
      r_win_idx      <= '0;
      r_win_valid    <= 1'b0;
      r_irr_clear    <= '0;
      r_vector_out   <= '0;
      r_vector_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state        <= w_state_next;
      r_int_out      <= (w_state_next == REQ);
      r_isr          <= (w_isr_post & ~w_aeoi_mask) | w_set_mask;
      r_base         <= w_base_next;
      r_irr_clear    <= w_set_mask;
      r_vector_valid <= w_ack2;
      if (w_ack1) begin
        r_win_idx   <= w_win_valid ? w_req_idx : SPURIOUS_IDX;
        r_win_valid <= w_win_valid;
      end
      if (w_ack2) r_vector_out <= {vector_base, r_win_idx};
    end
  end

  assign int_out              = r_int_out;
  assign irr_clear            = r_irr_clear;
  assign vector_out           = r_vector_out;
  assign vector_valid         = r_vector_valid;
  assign isr                  = r_isr;
  assign highest_priority_idx = r_base;

endmodule

// File: tb/tb_pic_ack_controller.sv
// Self-checking bench: directed scenarios then random traffic, every cycle
// compared against a rank-arithmetic model of the interrupt sequencer.
module tb_pic_ack_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_status, imr;
  logic [4:0] vector_base;
  logic       aeoi, rotate_en, inta_pulse, eoi_valid, eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] irr_clear, vector_out, isr;
  logic       vector_valid;
  logic [2:0] highest_priority_idx;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [7:0] m_isr, m_irrc, m_vec;
  int         m_base, m_win;
  bit         m_int, m_wait, m_vv, m_win_ok;

  pic_ack_controller dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .irq_status           (irq_status),
    .imr                  (imr),
    .vector_base          (vector_base),
    .aeoi                 (aeoi),
    .rotate_en            (rotate_en),
    .inta_pulse           (inta_pulse),
    .eoi_valid            (eoi_valid),
    .eoi_specific         (eoi_specific),
    .eoi_level            (eoi_level),
    .int_out              (int_out),
    .irr_clear            (irr_clear),
    .vector_out           (vector_out),
    .vector_valid         (vector_valid),
    .isr                  (isr),
    .highest_priority_idx (highest_priority_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int prio_rank(input int lvl, input int base);
    return (lvl - base + 8) % 8;
  endfunction

  // Highest-priority set level of v for a given base, or -1 when v is empty.
  function automatic int top_of(input logic [7:0] v, input int base);
    for (int r = 0; r < 8; r++) begin
      if (v[(base + r) % 8]) return (base + r) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_isr = '0; m_irrc = '0; m_vec = '0;
    m_base = 0; m_win = 0;
    m_int = 0; m_wait = 0; m_vv = 0; m_win_ok = 0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".int_out"},   {7'd0, int_out},      {7'd0, m_int});
    chk({where, ".irr_clear"}, irr_clear,            m_irrc);
    chk({where, ".isr"},       isr,                  m_isr);
    chk({where, ".hpi"},       {5'd0, highest_priority_idx}, 8'(m_base));
    chk({where, ".vvalid"},    {7'd0, vector_valid}, {7'd0, m_vv});
    if (m_vv) chk({where, ".vector"}, vector_out, m_vec);
  endtask

  // One clock: evaluate the model on the current inputs, clock the DUT, compare.
  task automatic cyc(input string where);
    logic [7:0] isr_post, set_m, aeoi_m;
    int lvl, w, n_base;
    bit ok, ack1, ack2, n_int, n_wait;
    isr_post = m_isr;
    n_base   = m_base;
    if (eoi_valid) begin
      lvl = eoi_specific ? int'(eoi_level) : top_of(m_isr, m_base);
      if (lvl >= 0 && m_isr[lvl]) begin
        isr_post[lvl] = 1'b0;
        if (rotate_en) n_base = (lvl + 1) % 8;
      end
    end
    w  = top_of(irq_status & ~imr, m_base);
    ok = (w >= 0);
    for (int j = 0; j < 8; j++) begin
      if (ok && isr_post[j] && prio_rank(j, m_base) <= prio_rank(w, m_base)) ok = 0;
    end
    ack1 = m_int && inta_pulse;
    ack2 = m_wait && inta_pulse;
    set_m = '0;
    aeoi_m = '0;
    if (ack2) begin
      m_vec = {vector_base, 3'(m_win)};
      if (aeoi && m_win_ok) begin
        aeoi_m[m_win] = 1'b1;
        if (rotate_en) n_base = (m_win + 1) % 8;
      end
    end
    if (ack1) begin
      m_win    = ok ? w : 7;
      m_win_ok = ok;
      if (ok) set_m[w] = 1'b1;
    end
    n_int  = ok && !m_wait && !m_vv && !ack1;
    n_wait = ack1 || (m_wait && !inta_pulse);
    @(posedge clk);
    #1;
    m_vv   = ack2;
    m_wait = n_wait;
    m_int  = n_int;
    m_irrc = set_m;
    m_isr  = (isr_post & ~aeoi_m) | set_m;
    m_base = n_base;
    check_all(where);
  endtask

  task automatic inta(input string where);
    inta_pulse = 1'b1;
    cyc(where);
    inta_pulse = 1'b0;
  endtask

  task automatic eoi(input string where, input bit specific, input logic [2:0] level);
    eoi_valid = 1'b1; eoi_specific = specific; eoi_level = level;
    cyc(where);
    eoi_valid = 1'b0; eoi_specific = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    irq_status = '0; imr = '0; vector_base = 5'h08;
    aeoi = 1'b0; rotate_en = 1'b0; inta_pulse = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.vector_out", vector_out, 8'h00);
    #3 rst_n = 1'b1;
    cyc("idle");

    // Single request on IRQ0, full acknowledge.
    irq_status = 8'h01;
    cyc("t1_req");
    chk("t1_int_raised", {7'd0, int_out}, 8'h01);
    inta("t1_ack1");
    chk("t1_irr_clear", irr_clear, 8'h01);
    chk("t1_isr", isr, 8'h01);
    irq_status = 8'h00;
    cyc("t1_wait");
    inta("t1_ack2");
    chk("t1_vector", vector_out, 8'h40);
    cyc("t1_done");
    eoi("t1_eoi", 1'b0, 3'd0);

    // Several requests: IRQ0 first, then IRQ2 after a non-specific EOI.
    irq_status = 8'h55;
    cyc("t2_req");
    inta("t2_ack1");
    irq_status = 8'h54;
    inta("t2_ack2");
    chk("t2_vector", vector_out, 8'h40);
    cyc("t2_hold");
    chk("t2_blocked", {7'd0, int_out}, 8'h00);
    eoi("t2_eoi", 1'b0, 3'd0);
    chk("t2_isr_clear", isr, 8'h00);
    chk("t2_reraise", {7'd0, int_out}, 8'h01);
    inta("t2_ack1b");
    irq_status = 8'h00;
    inta("t2_ack2b");
    chk("t2_vector_irq2", vector_out, 8'h42);
    cyc("t2_done");

    // Nesting: IRQ2 in service blocks IRQ5, lets IRQ1 through.
    irq_status = 8'h20;
    repeat (3) cyc("t3_blocked");
    chk("t3_no_int", {7'd0, int_out}, 8'h00);
    irq_status = 8'h22;
    cyc("t3_nested");
    chk("t3_int", {7'd0, int_out}, 8'h01);
    inta("t3_ack1");
    irq_status = 8'h20;
    inta("t3_ack2");
    irq_status = 8'h00;
    eoi("t3_eoi_a", 1'b1, 3'd1);
    eoi("t3_eoi_b", 1'b1, 3'd2);
    eoi("t3_eoi_noop", 1'b1, 3'd6);

    // Rotation.
    rotate_en = 1'b1;
    irq_status = 8'h80;
    cyc("t4_req7");
    inta("t4_ack1");
    irq_status = 8'h00;
    inta("t4_ack2");
    eoi("t4_eoi7", 1'b1, 3'd7);
    chk("t4_base0", {5'd0, highest_priority_idx}, 8'h00);
    irq_status = 8'h08;
    cyc("t4_req3");
    inta("t4_ack1b");
    irq_status = 8'h00;
    inta("t4_ack2b");
    eoi("t4_eoi3", 1'b1, 3'd3);
    chk("t4_base4", {5'd0, highest_priority_idx}, 8'h04);
    irq_status = 8'h11;
    cyc("t4_req");
    inta("t4_ack1c");
    chk("t4_irq4_wins", irr_clear, 8'h10);
    irq_status = 8'h01;
    inta("t4_ack2c");
    chk("t4_vector4", vector_out, 8'h44);
    irq_status = 8'h00;
    eoi("t4_eoi4", 1'b0, 3'd0);
    rotate_en = 1'b0;

    // Spurious: request vanishes in the same cycle as INTA #1.
    irq_status = 8'h08;
    cyc("t5_req");
    irq_status = 8'h00;
    inta("t5_ack1");
    chk("t5_irr_clear", irr_clear, 8'h00);
    inta("t5_ack2");
    chk("t5_vector", vector_out, {5'h08, 3'd7});
    cyc("t5_done");

    // Automatic EOI, then reset asserted while waiting for INTA #2.
    aeoi = 1'b1;
    irq_status = 8'h02;
    cyc("t6_req");
    inta("t6_ack1");
    chk("t6_isr_set", isr & 8'h02, 8'h02);
    irq_status = 8'h00;
    inta("t6_ack2");
    chk("t6_isr_cleared", isr & 8'h02, 8'h00);
    cyc("t6_done");
    irq_status = 8'h04;
    cyc("t6_req2");
    inta("t6_ack1b");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_reset");
    chk("t6_reset_vector", vector_out, 8'h00);
    #2 rst_n = 1'b1;
    aeoi = 1'b0;
    irq_status = 8'h00;
    cyc("t6_after");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) irq_status = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 31) == 0) imr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 31) == 0) aeoi = ~aeoi;
      if ($urandom_range(0, 31) == 0) rotate_en = ~rotate_en;
      if ($urandom_range(0, 15) == 0) vector_base = 5'($urandom);
      inta_pulse   = ($urandom_range(0, 3) == 0);
      eoi_valid    = ($urandom_range(0, 7) == 0);
      eoi_specific = 1'($urandom_range(0, 1));
      eoi_level    = 3'($urandom_range(0, 7));
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
